// File: rtl/timer_irq_peripheral_if.sv
// ---------------------------------------------------------------------------
// timer_irq_peripheral_if
//   Data-memory bus bundle between the CPU load/store path and the timer.
//
//   rd     MemRead strobe
//   wr     MemWrite strobe
//   addr   byte address from the ALU
//   wdata  store data (rt value)
//   rdata  load data returned by the peripheral (combinational)
//
//   master : CPU side    slave : peripheral side
// ---------------------------------------------------------------------------
interface timer_irq_peripheral_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_peripheral.sv
// ---------------------------------------------------------------------------
// timer_irq_peripheral
//   Memory-mapped interval timer that drives the CPU IRQ line. TL counts up
//   on every enabled tick and reloads from TH when it passes 32'hFFFF_FFFF.
//   An overflow with IE=1 sets the sticky status bit ST, which is the level
//   interrupt; software clears it by writing TCON with ST=0.
//
//   Register window (exact 32-bit address match):
//     ADDR_BASE+0x0  TH    reload value
//     ADDR_BASE+0x4  TL    counter
//     ADDR_BASE+0x8  TCON  {29'b0, ST, IE, EN}
//     ADDR_BASE+0xC  PRE   prescale reload (TIMER_PRESCALE_EN only)
//
//   Build option: define TIMER_PRESCALE_EN to add PRE and a down-counter PC
//   so that TL only ticks once every PRE+1 enabled cycles. Without it,
//   base+0xC reads 0 and the timer ticks on every enabled cycle.
//
//   Ports:
//     clk     system clock, rising edge
//     reset   asynchronous, active-high reset
//     bus     slave side of timer_irq_peripheral_if (rd, wr, addr, wdata, rdata)
//     irqout  interrupt request, equal to TCON.ST
// ---------------------------------------------------------------------------
module timer_irq_peripheral #(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    timer_irq_peripheral_if.slave        bus,
    output logic                         irqout
);

    localparam logic [31:0] ADDR_TH   = ADDR_BASE + 32'h0;
    localparam logic [31:0] ADDR_TL   = ADDR_BASE + 32'h4;
    localparam logic [31:0] ADDR_TCON = ADDR_BASE + 32'h8;
`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] ADDR_PRE  = ADDR_BASE + 32'hC;
`endif

    typedef struct packed {
        logic st;   // interrupt status (sticky)
        logic ie;   // interrupt enable
        logic en;   // count enable
    } tcon_t;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    tcon_t       tcon_q, tcon_d;
`ifdef TIMER_PRESCALE_EN
    logic [31:0] pre_q, pre_d;
    logic [31:0] pc_q, pc_d;
`endif

    // Address decode
    logic sel_th, sel_tl, sel_tcon;
    logic wr_th, wr_tl, wr_tcon;
`ifdef TIMER_PRESCALE_EN
    logic sel_pre, wr_pre;
`endif

    always_comb begin
        sel_th   = (bus.addr == ADDR_TH);
        sel_tl   = (bus.addr == ADDR_TL);
        sel_tcon = (bus.addr == ADDR_TCON);
        wr_th    = bus.wr && sel_th;
        wr_tl    = bus.wr && sel_tl;
        wr_tcon  = bus.wr && sel_tcon;
`ifdef TIMER_PRESCALE_EN
        sel_pre  = (bus.addr == ADDR_PRE);
        wr_pre   = bus.wr && sel_pre;
`endif
    end

    // Tick generation
    logic tick;
    logic overflow;

`ifdef TIMER_PRESCALE_EN
    always_comb begin
        tick  = tcon_q.en && (pc_q == 32'd0);
        pre_d = pre_q;
        pc_d  = pc_q;
        // A PRE write restarts the prescale interval from the new value.
        if (wr_pre) begin
            pre_d = bus.wdata;
            pc_d  = bus.wdata;
        end else if (tcon_q.en) begin
            pc_d = (pc_q == 32'd0) ? pre_q : pc_q - 32'd1;
        end
    end
`else
    always_comb tick = tcon_q.en;
`endif

    assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

    // Next-state logic
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (tick) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        // Overflow consults IE before any same-edge TCON write.
        if (overflow && tcon_q.ie) begin
            tcon_d.st = 1'b1;
        end

        // CPU writes win over the count; reload above already used old TH.
        if (wr_th) begin
            th_d = bus.wdata;
        end
        if (wr_tl) begin
            tl_d = bus.wdata;
        end
        if (wr_tcon) begin
            tcon_d.en = bus.wdata[0];
            tcon_d.ie = bus.wdata[1];
            // An acknowledge landing on an interrupting overflow must not
            // drop the new interrupt.
            tcon_d.st = bus.wdata[2] | (overflow && tcon_q.ie);
        end
    end

    // State registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
`ifdef TIMER_PRESCALE_EN
            pre_q  <= '0;
            pc_q   <= '0;
`endif
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
`ifdef TIMER_PRESCALE_EN
            pre_q  <= pre_d;
            pc_q   <= pc_d;
`endif
        end
    end

    // Read mux: combinational, no side effects, 0 when idle or unmapped.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            if (sel_th) begin
                bus.rdata = th_q;
            end else if (sel_tl) begin
                bus.rdata = tl_q;
            end else if (sel_tcon) begin
                bus.rdata = {29'd0, tcon_q};
`ifdef TIMER_PRESCALE_EN
            end else if (sel_pre) begin
                bus.rdata = pre_q;
`endif
            end
        end
    end

    assign irqout = tcon_q.st;

endmodule

// File: tb/tb_timer_irq_peripheral.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_peripheral
//   Self-checking bench for timer_irq_peripheral: a hand-computed vector
//   table, an asynchronous reset sequence, a prescaler sequence (when
//   TIMER_PRESCALE_EN is defined) and randomized bus traffic compared with a
//   behavioural model of the register map.
// ---------------------------------------------------------------------------
module tb_timer_irq_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_PRE  = 32'h4000_000C;
    localparam logic [31:0] A_OUT  = 32'h4000_0010;
    localparam logic [31:0] MAX    = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    logic irqout;

    timer_irq_peripheral_if bus ();

    timer_irq_peripheral dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.rd    = rd;
        bus.wr    = wr;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t rv(input logic [31:0] a, input logic [31:0] exp, input logic irq);
        vec_t v;
        v.rd = 1'b1; v.wr = 1'b0; v.addr = a; v.wdata = 32'd0;
        v.exp_rdata = exp; v.exp_irq = irq;
        return v;
    endfunction

    function automatic vec_t wv(input logic [31:0] a, input logic [31:0] d, input logic irq);
        vec_t v;
        v.rd = 1'b0; v.wr = 1'b1; v.addr = a; v.wdata = d;
        v.exp_rdata = 32'd0; v.exp_irq = irq;
        return v;
    endfunction

    // Each entry: inputs held for one cycle; rdata/irq checked before the edge.
    task automatic fill_table();
        vecs.push_back(rv(A_TCON, 32'h0, 1'b0));
        vecs.push_back(wv(A_TH, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(wv(A_TL, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(rv(A_TH, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(wv(A_TCON, 32'h3, 1'b0));           // enable, IE
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFD, 1'b0));
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFE, 1'b0));
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFF, 1'b0));      // overflow edge
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFC, 1'b1));      // reloaded, irq up
        vecs.push_back(rv(A_TCON, 32'h7, 1'b1));
        vecs.push_back(wv(A_TCON, 32'h3, 1'b1));            // ack at TL=FE
        vecs.push_back(rv(A_TCON, 32'h3, 1'b0));            // TL=FF -> overflow
        vecs.push_back(rv(A_TCON, 32'h7, 1'b1));
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFD, 1'b1));
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFE, 1'b1));
        vecs.push_back(wv(A_TCON, 32'h3, 1'b1));            // ack races overflow
        vecs.push_back(rv(A_TCON, 32'h7, 1'b1));            // ST kept
        vecs.push_back(wv(A_TL, 32'h10, 1'b1));             // write beats tick
        vecs.push_back(rv(A_TL, 32'h10, 1'b1));
        vecs.push_back(rv(A_OUT, 32'h0, 1'b1));             // unmapped
        vecs.push_back(wv(A_TCON, 32'h3, 1'b1));            // ack, no overflow
        vecs.push_back(rv(A_TCON, 32'h3, 1'b0));
        vecs.push_back(wv(A_TCON, 32'h1, 1'b0));            // IE=0
        vecs.push_back(wv(A_TL, MAX, 1'b0));
        vecs.push_back(rv(A_TL, MAX, 1'b0));                // overflow, IE=0
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(rv(A_TCON, 32'h1, 1'b0));
        vecs.push_back(wv(A_TCON, 32'h3, 1'b0));            // TL FE -> FF
        vecs.push_back(wv(A_TH, 32'h100, 1'b0));            // TH write on overflow
        vecs.push_back(rv(A_TL, 32'hFFFF_FFFC, 1'b1));      // old TH reloaded
        vecs.push_back(rv(A_TH, 32'h100, 1'b1));
        vecs.push_back(rv(A_PRE, 32'h0, 1'b1));             // TL FE -> FF
        vecs.push_back(wv(A_TCON, 32'hFFFF_FFF8, 1'b1));    // ST=0 write on IE overflow
        vecs.push_back(rv(A_TCON, 32'h4, 1'b1));
        vecs.push_back(rv(A_TL, 32'h100, 1'b1));            // EN=0 holds
        vecs.push_back(wv(A_TCON, 32'h0, 1'b1));
        vecs.push_back(rv(A_TCON, 32'h0, 1'b0));
        vecs.push_back(wv(A_TCON, 32'h4, 1'b0));            // test interrupt
        vecs.push_back(rv(A_TCON, 32'h4, 1'b1));
        vecs.push_back(rv(32'h0000_0004, 32'h0, 1'b1));     // upper bits differ
        vecs.push_back(rv(A_TL, 32'h100, 1'b1));
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_th, m_tl, m_pre, m_pc;
    logic        m_en, m_ie, m_st;

    task automatic m_reset();
        m_th = 0; m_tl = 0; m_pre = 0; m_pc = 0;
        m_en = 0; m_ie = 0; m_st = 0;
    endtask

    function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
        if (!rd) return 32'd0;
        if (a == A_TH) return m_th;
        if (a == A_TL) return m_tl;
        if (a == A_TCON) return {29'd0, m_st, m_ie, m_en};
`ifdef TIMER_PRESCALE_EN
        if (a == A_PRE) return m_pre;
`endif
        return 32'd0;
    endfunction

    task automatic m_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic        tk, ovf, irq_new;
        logic [31:0] n_th, n_tl, n_pre, n_pc;
        logic        n_en, n_ie, n_st;
`ifdef TIMER_PRESCALE_EN
        tk = m_en && (m_pc == 0);
`else
        tk = m_en;
`endif
        ovf     = tk && (m_tl == MAX);
        irq_new = ovf && m_ie;
        n_th = m_th; n_tl = m_tl; n_pre = m_pre; n_pc = m_pc;
        n_en = m_en; n_ie = m_ie; n_st = m_st | irq_new;
        if (tk) n_tl = ovf ? m_th : m_tl + 1;
        if (m_en) n_pc = (m_pc == 0) ? m_pre : m_pc - 1;
        if (wr) begin
            if (a == A_TH) n_th = d;
            if (a == A_TL) n_tl = d;
            if (a == A_TCON) begin
                n_en = d[0];
                n_ie = d[1];
                n_st = d[2] | irq_new;
            end
`ifdef TIMER_PRESCALE_EN
            if (a == A_PRE) begin
                n_pre = d;
                n_pc  = d;
            end
`endif
        end
        m_th = n_th; m_tl = n_tl; m_pre = n_pre; m_pc = n_pc;
        m_en = n_en; m_ie = n_ie; m_st = n_st;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #12;
        reset = 1'b0;
        next_cycle();

        // Table-driven directed vectors
        fill_table();
        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec[%0d] rdata", i), bus.rdata, vecs[i].exp_rdata);
            check($sformatf("vec[%0d] irq", i), {31'd0, irqout}, {31'd0, vecs[i].exp_irq});
            next_cycle();
        end

        // Asynchronous reset mid-cycle with ST=1, TL=TH=0x100
        drive(1'b1, 1'b0, A_TL, 32'd0);
        #1;
        check("pre-reset TL", bus.rdata, 32'h100);
        check("pre-reset irq", {31'd0, irqout}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset irq", {31'd0, irqout}, 32'd0);
        check("async reset TL", bus.rdata, 32'd0);
        bus.addr = A_TH;
        #1;
        check("async reset TH", bus.rdata, 32'd0);
        bus.addr = A_TCON;
        #1;
        check("async reset TCON", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        next_cycle();

`ifdef TIMER_PRESCALE_EN
        // Prescaler: PRE=2 -> TL advances once every 3 enabled cycles
        drive(1'b0, 1'b1, A_PRE, 32'd2);              next_cycle();
        drive(1'b0, 1'b1, A_TH, 32'hFFFF_FFFE);       next_cycle();
        drive(1'b0, 1'b1, A_TL, 32'hFFFF_FFFE);       next_cycle();
        drive(1'b0, 1'b1, A_TCON, 32'h3);             next_cycle();
        for (int k = 0; k < 9; k++) begin
            logic [31:0] exp_tl;
            logic        exp_irq;
            exp_tl  = (k < 3) ? 32'hFFFF_FFFE : (k < 6) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            exp_irq = (k >= 6);
            drive(1'b1, 1'b0, A_TL, 32'd0);
            #1;
            check($sformatf("prescale TL k=%0d", k), bus.rdata, exp_tl);
            check($sformatf("prescale irq k=%0d", k), {31'd0, irqout}, {31'd0, exp_irq});
            next_cycle();
        end
        do_reset();
`endif

        // Randomized traffic against the model
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            logic        rd, wr;
            logic [31:0] a, d;
            rd = ($urandom_range(0, 9) < 6);
            wr = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 6))
                0: a = A_TH;
                1, 2: a = A_TL;
                3, 4: a = A_TCON;
                5: a = A_PRE;
                default: a = ($urandom_range(0, 1) == 0) ? A_OUT : $urandom;
            endcase
            if (a == A_TL || a == A_TH)
                d = ($urandom_range(0, 3) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            else if (a == A_PRE)
                d = 32'($urandom_range(0, 3));
            else if (a == A_TCON)
                d = ($urandom_range(0, 3) != 0) ? (32'($urandom_range(0, 7)) | 32'h1) : $urandom;
            else
                d = $urandom;
            drive(rd, wr, a, d);
            #1;
            check($sformatf("rand[%0d] rdata", c), bus.rdata, m_read(rd, a));
            check($sformatf("rand[%0d] irq", c), {31'd0, irqout}, {31'd0, m_st});
            m_step(wr, a, d);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
